// File: rtl/signed_vacc_sat_if.sv
// Sample/result bundle for signed_vacc_sat.
// master drives samples and control; slave is the accumulator.
interface signed_vacc_sat_if #(
   parameter int DIN_WIDTH     = 16,
   parameter int ACC_WIDTH     = 32,
   parameter int CHANNELS      = 4,
   parameter int ACC_LEN_WIDTH = 16
);
   logic [CHANNELS*DIN_WIDTH-1:0] din;
   logic                          din_valid;
   logic [ACC_LEN_WIDTH-1:0]      acc_len;
   logic                          sync;
   logic [CHANNELS*ACC_WIDTH-1:0] dout;
   logic                          dout_valid;
   logic [CHANNELS-1:0]           ovf;

   modport master (
      output din, din_valid, acc_len, sync,
      input  dout, dout_valid, ovf
   );

   modport slave (
      input  din, din_valid, acc_len, sync,
      output dout, dout_valid, ovf
   );
endinterface

// File: rtl/signed_vacc_sat.sv
// Multi-lane signed frame accumulator with internal frame counter,
// sticky per-lane overflow and optional saturation.
module signed_vacc_sat #(
   parameter int DIN_WIDTH     = 16,
   parameter int ACC_WIDTH     = 32,
   parameter int CHANNELS      = 4,
   parameter int ACC_LEN_WIDTH = 16,
   parameter bit SATURATE      = 1'b1
) (
   input logic              clk,
   input logic              rst,
   signed_vacc_sat_if.slave bus
);
   localparam logic [ACC_LEN_WIDTH-1:0] LEN_ONE = ACC_LEN_WIDTH'(1);

   logic [CHANNELS*DIN_WIDTH-1:0] din_r;
   logic                          vld_r;
   logic                          sync_r;
   logic [ACC_LEN_WIDTH-1:0]      cnt;
   logic [ACC_LEN_WIDTH-1:0]      len_r;
   logic [CHANNELS*ACC_WIDTH-1:0] acc;
   logic [CHANNELS-1:0]           ovf_acc;
   logic [CHANNELS*ACC_WIDTH-1:0] dout_q;
   logic                          dout_valid_q;
   logic [CHANNELS-1:0]           ovf_q;

   logic                          start;
   logic                          last;
   logic [ACC_LEN_WIDTH-1:0]      len_in;
   logic [ACC_LEN_WIDTH-1:0]      len_eff;
   logic [ACC_LEN_WIDTH-1:0]      pos;
   logic [CHANNELS*ACC_WIDTH-1:0] acc_nxt;
   logic [CHANNELS-1:0]           ovf_nxt;

   // A registered sync makes the current sample position 0 and relatches the
   // length, so a frame start uses the live acc_len rather than the old len_r.
   always_comb begin
      start   = sync_r || (cnt == '0);
      len_in  = (bus.acc_len == '0) ? LEN_ONE : bus.acc_len;
      len_eff = start ? len_in : len_r;
      pos     = start ? '0 : cnt;
      last    = (pos == len_eff - LEN_ONE);
   end

   for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
      logic signed [ACC_WIDTH-1:0] base;
      logic signed [ACC_WIDTH-1:0] smp;
      logic signed [ACC_WIDTH:0]   sum;
      logic signed [ACC_WIDTH-1:0] res;
      logic                        lane_ovf;

      always_comb begin
         base     = start ? '0 : $signed(acc[k*ACC_WIDTH +: ACC_WIDTH]);
         smp      = ACC_WIDTH'($signed(din_r[k*DIN_WIDTH +: DIN_WIDTH]));
         sum      = (ACC_WIDTH+1)'(base) + (ACC_WIDTH+1)'(smp);
         lane_ovf = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
         if (lane_ovf && SATURATE)
            res = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                 : {1'b0, {(ACC_WIDTH-1){1'b1}}};
         else
            res = sum[ACC_WIDTH-1:0];
      end

      assign acc_nxt[k*ACC_WIDTH +: ACC_WIDTH] = res;
      assign ovf_nxt[k] = lane_ovf | (~start & ovf_acc[k]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         din_r        <= '0;
         vld_r        <= 1'b0;
         sync_r       <= 1'b0;
         cnt          <= '0;
         len_r        <= LEN_ONE;
         acc          <= '0;
         ovf_acc      <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         ovf_q        <= '0;
      end else begin
         din_r        <= bus.din;
         vld_r        <= bus.din_valid;
         sync_r       <= bus.sync;
         dout_valid_q <= 1'b0;
         if (vld_r) begin
            acc     <= acc_nxt;
            ovf_acc <= ovf_nxt;
            len_r   <= len_eff;
            if (last) begin
               cnt          <= '0;
               dout_q       <= acc_nxt;
               ovf_q        <= ovf_nxt;
               dout_valid_q <= 1'b1;
            end else begin
               cnt <= pos + LEN_ONE;
            end
         end else if (sync_r) begin
            cnt <= '0;
         end
      end
   end

   assign bus.dout       = dout_q;
   assign bus.dout_valid = dout_valid_q;
   assign bus.ovf        = ovf_q;
endmodule

// File: tb/tb_signed_vacc_sat.sv
// Directed bench for signed_vacc_sat: saturating and wrapping instances share
// one stimulus stream; 18-bit accumulators make overflow reachable.
module tb_signed_vacc_sat;
   localparam int DW = 16;
   localparam int AW = 18;
   localparam int CH = 4;
   localparam int LW = 16;

   logic clk = 1'b0;
   logic rst;
   int   n_asrt = 0;
   int   n_fail = 0;
   int   nval   = 0;
   int   n0;

   signed_vacc_sat_if #(.DIN_WIDTH(DW), .ACC_WIDTH(AW), .CHANNELS(CH), .ACC_LEN_WIDTH(LW)) ifa ();
   signed_vacc_sat_if #(.DIN_WIDTH(DW), .ACC_WIDTH(AW), .CHANNELS(CH), .ACC_LEN_WIDTH(LW)) ifb ();

   assign ifb.din       = ifa.din;
   assign ifb.din_valid = ifa.din_valid;
   assign ifb.acc_len   = ifa.acc_len;
   assign ifb.sync      = ifa.sync;

   signed_vacc_sat #(.DIN_WIDTH(DW), .ACC_WIDTH(AW), .CHANNELS(CH),
                     .ACC_LEN_WIDTH(LW), .SATURATE(1'b1)) dut_sat (
      .clk(clk), .rst(rst), .bus(ifa.slave));

   signed_vacc_sat #(.DIN_WIDTH(DW), .ACC_WIDTH(AW), .CHANNELS(CH),
                     .ACC_LEN_WIDTH(LW), .SATURATE(1'b0)) dut_wrap (
      .clk(clk), .rst(rst), .bus(ifb.slave));

   always #5 clk = ~clk;

   // A pulse visible after edge e is counted at edge e+1.
   always @(posedge clk) if (ifa.dout_valid === 1'b1) nval++;

   function automatic longint lane(input logic [CH*AW-1:0] v, input int k);
      logic signed [AW-1:0] t;
      t = v[k*AW +: AW];
      return longint'(t);
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic v, input logic s, input int l0, input int l1,
                       input int l2, input int l3);
      ifa.din_valid = v;
      ifa.sync      = s;
      ifa.din       = {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
      cyc();
   endtask

   task automatic idle();
      send(1'b0, 1'b0, 0, 0, 0, 0);
   endtask

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_a(input string tag, input logic dv, input longint e0, input longint e1,
                        input longint e2, input longint e3, input logic [3:0] ov);
      chk({tag, " dv"},   longint'(ifa.dout_valid), longint'(dv));
      chk({tag, " l0"},   lane(ifa.dout, 0), e0);
      chk({tag, " l1"},   lane(ifa.dout, 1), e1);
      chk({tag, " l2"},   lane(ifa.dout, 2), e2);
      chk({tag, " l3"},   lane(ifa.dout, 3), e3);
      chk({tag, " ovf"},  longint'(ifa.ovf), longint'(ov));
   endtask

   initial begin
      rst = 1'b1;
      ifa.din = '0; ifa.din_valid = 1'b0; ifa.sync = 1'b0; ifa.acc_len = 16'd4;
      cyc(); cyc();
      chk_a("reset", 1'b0, 0, 0, 0, 0, 4'b0000);
      chk("reset wrap dout", longint'(ifb.dout == '0), 1);
      rst = 1'b0;
      cyc();

      // 1: basic accumulation, two back-to-back frames of 4
      ifa.acc_len = 16'd4;
      for (int i = 0; i < 8; i++) begin
         send(1'b1, 1'b0, 1, 2, 3, 4);
         if (i == 4) chk_a("basic f1", 1'b1, 4, 8, 12, 16, 4'b0000);
         if (i == 5) chk("basic gap dv", longint'(ifa.dout_valid), 0);
      end
      idle();
      chk_a("basic f2", 1'b1, 4, 8, 12, 16, 4'b0000);
      idle();
      chk_a("basic hold", 1'b0, 4, 8, 12, 16, 4'b0000);

      // 2: gapped input, 5 - 7 + 100 = 98
      ifa.acc_len = 16'd3;
      send(1'b1, 1'b0, 5, 0, 0, 0);
      idle();
      send(1'b1, 1'b0, -7, 0, 0, 0);
      idle();
      send(1'b1, 1'b0, 100, 0, 0, 0);
      chk("gap early dv", longint'(ifa.dout_valid), 0);
      idle();
      chk_a("gap dump", 1'b1, 98, 0, 0, 0, 4'b0000);
      idle();
      chk("gap single pulse", longint'(ifa.dout_valid), 0);

      // 3: 8 x 32767 = 262136 -> clamp 131071 / wrap -8; 8 x -32768 -> -131072 / wrap 0
      ifa.acc_len = 16'd8;
      for (int i = 0; i < 8; i++) send(1'b1, 1'b0, 32767, -32768, 0, 0);
      idle();
      chk_a("sat", 1'b1, 131071, -131072, 0, 0, 4'b0011);
      chk("wrap l0",  lane(ifb.dout, 0), -8);
      chk("wrap l1",  lane(ifb.dout, 1), 0);
      chk("wrap ovf", longint'(ifb.ovf), 3);
      idle();

      // 4: sync mid-frame, then sync on the would-be last sample
      ifa.acc_len = 16'd4;
      n0 = nval;
      send(1'b1, 1'b0, 1, 0, 0, 0);
      send(1'b1, 1'b0, 1, 0, 0, 0);
      send(1'b1, 1'b1, 10, 0, 0, 0);
      send(1'b1, 1'b0, 20, 0, 0, 0);
      send(1'b1, 1'b0, 30, 0, 0, 0);
      send(1'b1, 1'b0, 40, 0, 0, 0);
      idle();
      chk_a("sync dump", 1'b1, 100, 0, 0, 0, 4'b0000);
      chk("sync no partial", longint'(nval), longint'(n0));
      idle();
      ifa.acc_len = 16'd2;
      n0 = nval;
      send(1'b1, 1'b0, 7, 0, 0, 0);
      send(1'b1, 1'b1, 9, 0, 0, 0);
      send(1'b1, 1'b0, 11, 0, 0, 0);
      idle();
      chk("sync last dv", longint'(ifa.dout_valid), 1);
      chk("sync last l0", lane(ifa.dout, 0), 20);
      chk("sync last dropped", longint'(nval), longint'(n0));
      idle();

      // 5: length change mid-frame, then lengths 0 and 1
      ifa.acc_len = 16'd4;
      send(1'b1, 1'b0, 1, 0, 0, 0);
      send(1'b1, 1'b0, 1, 0, 0, 0);
      ifa.acc_len = 16'd2;
      send(1'b1, 1'b0, 1, 0, 0, 0);
      send(1'b1, 1'b0, 1, 0, 0, 0);
      send(1'b1, 1'b0, 3, 0, 0, 0);
      chk("len old dv", longint'(ifa.dout_valid), 1);
      chk("len old l0", lane(ifa.dout, 0), 4);
      send(1'b1, 1'b0, 3, 0, 0, 0);
      chk("len new mid dv", longint'(ifa.dout_valid), 0);
      idle();
      chk("len new dv", longint'(ifa.dout_valid), 1);
      chk("len new l0", lane(ifa.dout, 0), 6);
      idle();
      ifa.acc_len = 16'd0;
      send(1'b1, 1'b0, 5, 0, 0, 0);
      send(1'b1, 1'b0, -3, 0, 0, 0);
      chk("len0 a dv", longint'(ifa.dout_valid), 1);
      chk("len0 a l0", lane(ifa.dout, 0), 5);
      idle();
      chk("len0 b dv", longint'(ifa.dout_valid), 1);
      chk("len0 b l0", lane(ifa.dout, 0), -3);
      idle();
      chk("len0 end dv", longint'(ifa.dout_valid), 0);
      ifa.acc_len = 16'd1;
      send(1'b1, 1'b0, -32768, 0, 0, 0);
      idle();
      chk("len1 dv", longint'(ifa.dout_valid), 1);
      chk("len1 l0", lane(ifa.dout, 0), -32768);
      idle();

      // 6: reset after 3 of 4 samples; the sample presented with rst is discarded
      ifa.acc_len = 16'd4;
      for (int i = 0; i < 3; i++) send(1'b1, 1'b0, 2, 2, 2, 2);
      rst = 1'b1;
      send(1'b1, 1'b0, 50, 50, 50, 50);
      rst = 1'b0;
      chk_a("rst", 1'b0, 0, 0, 0, 0, 4'b0000);
      chk("rst wrap dout", longint'(ifb.dout == '0), 1);
      n0 = nval;
      for (int i = 0; i < 4; i++) send(1'b1, 1'b0, 5, 6, 7, 8);
      idle();
      chk_a("post rst", 1'b1, 20, 24, 28, 32, 4'b0000);
      chk("post rst pulses", longint'(nval), longint'(n0));
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule
